// File: rtl/apb_master_bridge_if.sv
`default_nettype none
// ============================================================================
// Module   : apb_master_bridge_if
// Brief    : Request/response handshake plus APB4 bus bundle for the bridge.
// Revision : 1.0
// ============================================================================
interface apb_master_bridge_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  // Requester side
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_write;
  logic [DATA_W-1:0] req_wdata;
  logic [STRB_W-1:0] req_strb;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  // APB side
  logic              psel;
  logic              penable;
  logic [ADDR_W-1:0] paddr;
  logic              pwrite;
  logic [STRB_W-1:0] pstrb;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  // master: the bridge itself; slave: requester and APB completer together.
  modport master (
    input  req_valid, req_addr, req_write, req_wdata, req_strb, rsp_ready,
    input  prdata, pready, pslverr,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output psel, penable, paddr, pwrite, pstrb, pwdata
  );

  modport slave (
    output req_valid, req_addr, req_write, req_wdata, req_strb, rsp_ready,
    output prdata, pready, pslverr,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  psel, penable, paddr, pwrite, pstrb, pwdata
  );
endinterface

`default_nettype wire

// File: rtl/apb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module   : apb_master_bridge
// Brief    : Single-outstanding valid/ready to APB4 requester with timeout.
// Revision : 1.0
// ============================================================================
module apb_master_bridge #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                pclk,
  input  logic                presetn,
  apb_master_bridge_if.master bus
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  state_e            state_q,     state_d;
  logic              psel_q,      psel_d;
  logic              penable_q,   penable_d;
  logic [ADDR_W-1:0] paddr_q,     paddr_d;
  logic              pwrite_q,    pwrite_d;
  logic [STRB_W-1:0] pstrb_q,     pstrb_d;
  logic [DATA_W-1:0] pwdata_q,    pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q,   rsp_err_d;
  logic [CNT_W-1:0]  tcnt_q,      tcnt_d;
  logic              timeout_hit;

  // A late pready on the final allowed cycle is handled before this is consulted.
  if (TIMEOUT > 0) begin : g_timeout
    assign timeout_hit = (tcnt_q == CNT_W'(TIMEOUT - 1)) && !bus.pready;
  end else begin : g_no_timeout
    assign timeout_hit = 1'b0;
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pstrb_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      tcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pstrb_q     <= pstrb_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      tcnt_q      <= tcnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pstrb_d     = pstrb_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    tcnt_d      = tcnt_q;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          state_d   = SETUP;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          paddr_d   = bus.req_addr;
          pwrite_d  = bus.req_write;
          // Reads carry no strobes and a quiet data bus.
          pstrb_d   = bus.req_write ? bus.req_strb  : '0;
          pwdata_d  = bus.req_write ? bus.req_wdata : '0;
        end
      end

      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
        tcnt_d    = '0;
      end

      ACCESS: begin
        if (bus.pready) begin
          state_d     = RESP;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = bus.pslverr;
          rsp_rdata_d = pwrite_q ? '0 : bus.prdata;
        end else if (timeout_hit) begin
          state_d     = RESP;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end else begin
          tcnt_d = tcnt_q + CNT_W'(1);
        end
      end

      RESP: begin
        if (bus.rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.paddr     = paddr_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.pstrb     = pstrb_q;
  assign bus.pwdata    = pwdata_q;

endmodule

`default_nettype wire

// File: tb/tb_apb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_master_bridge
// Brief    : Directed self-checking bench for apb_master_bridge.
// Revision : 1.0
// ============================================================================
module tb_apb_master_bridge;

  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  logic pclk    = 1'b0;
  logic presetn = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  apb_master_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  apb_master_bridge #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .pclk   (pclk),
    .presetn(presetn),
    .bus    (bus)
  );

  always #5 pclk = ~pclk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  // Drives one request, plays the APB completer and checks up to the RESP cycle.
  task automatic run_xfer(input string tag, input logic [7:0] a, input logic w,
                          input logic [31:0] wd, input logic [3:0] st, input int waits,
                          input logic [31:0] rd, input logic se, input logic exp_err,
                          input logic [31:0] exp_rd, input int exp_acc);
    logic [46:0] exp_bus;
    int acc;
    check_eq({tag, ":req_ready"}, 64'(bus.req_ready), 64'd1);
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.req_write = w;
    bus.req_wdata = wd;
    bus.req_strb  = st;
    bus.pready    = 1'b0;
    bus.pslverr   = 1'b0;
    step();
    bus.req_valid = 1'b0;
    bus.req_addr  = ~a;
    bus.req_write = ~w;
    bus.req_wdata = ~wd;
    bus.req_strb  = ~st;
    exp_bus = {1'b1, 1'b0, a, w, (w ? st : 4'h0), (w ? wd : 32'h0)};
    check_eq({tag, ":setup"}, 64'({bus.psel, bus.penable, bus.paddr, bus.pwrite,
                                   bus.pstrb, bus.pwdata}), 64'(exp_bus));
    check_eq({tag, ":setup_hs"}, 64'({bus.req_ready, bus.rsp_valid}), 64'd0);
    step();
    exp_bus[45] = 1'b1;
    acc = 0;
    while (bus.psel && acc < 40) begin
      check_eq({tag, ":access"}, 64'({bus.psel, bus.penable, bus.paddr, bus.pwrite,
                                      bus.pstrb, bus.pwdata}), 64'(exp_bus));
      bus.pready  = (acc == waits);
      bus.pslverr = se && (acc == waits);
      bus.prdata  = rd;
      step();
      acc++;
    end
    bus.pready  = 1'b0;
    bus.pslverr = 1'b0;
    check_eq({tag, ":access_cycles"}, 64'(acc), 64'(exp_acc));
    check_eq({tag, ":resp"}, 64'({bus.psel, bus.penable, bus.rsp_valid, bus.rsp_err}),
             64'({1'b0, 1'b0, 1'b1, exp_err}));
    check_eq({tag, ":rdata"}, 64'(bus.rsp_rdata), 64'(exp_rd));
  endtask

  // Holds the response for `hold` extra cycles, then accepts it.
  task automatic release_rsp(input string tag, input int hold,
                             input logic [31:0] exp_rd, input logic exp_err);
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      step();
      check_eq({tag, ":hold"}, 64'({bus.rsp_valid, bus.rsp_err, bus.req_ready, bus.psel}),
               64'({1'b1, exp_err, 1'b0, 1'b0}));
      check_eq({tag, ":hold_rdata"}, 64'(bus.rsp_rdata), 64'(exp_rd));
    end
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    check_eq({tag, ":done"}, 64'({bus.rsp_valid, bus.req_ready}), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_write = 1'b0;
    bus.req_wdata = '0;
    bus.req_strb  = '0;
    bus.rsp_ready = 1'b0;
    bus.prdata    = '0;
    bus.pready    = 1'b0;
    bus.pslverr   = 1'b0;

    repeat (2) step();
    check_eq("reset_out", 64'({bus.psel, bus.penable, bus.rsp_valid, bus.rsp_err,
                                bus.rsp_rdata, bus.paddr, bus.pwrite, bus.pstrb}), 64'd0);
    check_eq("reset_ready", 64'(bus.req_ready), 64'd1);
    presetn = 1'b1;
    step();

    // Write, zero wait states; prdata noise must not reach rsp_rdata.
    run_xfer("t1_wr", 8'h10, 1'b1, 32'hDEADBEEF, 4'hF, 0, 32'hFFFFFFFF, 1'b0,
             1'b0, 32'h0, 1);
    release_rsp("t1", 0, 32'h0, 1'b0);

    // Read OK, then read with slave error.
    run_xfer("t2_rd", 8'h20, 1'b0, 32'hCAFEF00D, 4'hF, 0, 32'h12345679, 1'b0,
             1'b0, 32'h12345679, 1);
    release_rsp("t2a", 0, 32'h12345679, 1'b0);
    run_xfer("t2_err", 8'h24, 1'b0, 32'h0, 4'hF, 0, 32'hBAD00BAD, 1'b1,
             1'b1, 32'hBAD00BAD, 1);
    release_rsp("t2b", 0, 32'hBAD00BAD, 1'b1);

    // Write with three wait states: four ACCESS cycles.
    run_xfer("t3_wait", 8'h30, 1'b1, 32'h0BADF00D, 4'h5, 3, 32'h5555AAAA, 1'b0,
             1'b0, 32'h0, 4);
    release_rsp("t3", 0, 32'h0, 1'b0);

    // Timeout, then pready on the final allowed cycle.
    run_xfer("t4_tmo", 8'h40, 1'b0, 32'h0, 4'hF, 1000, 32'h13572468, 1'b0,
             1'b1, 32'h0, TIMEOUT);
    release_rsp("t4a", 0, 32'h0, 1'b1);
    run_xfer("t4_late", 8'h44, 1'b0, 32'h0, 4'hF, TIMEOUT - 1, 32'h13572468, 1'b0,
             1'b0, 32'h13572468, TIMEOUT);
    release_rsp("t4b", 0, 32'h13572468, 1'b0);

    // Response back-pressure with a new request already waiting.
    run_xfer("t5_a", 8'h50, 1'b0, 32'h0, 4'hF, 0, 32'h00C0FFEE, 1'b0,
             1'b0, 32'h00C0FFEE, 1);
    bus.req_valid = 1'b1;
    bus.req_addr  = 8'h54;
    bus.req_write = 1'b1;
    bus.req_wdata = 32'h11223344;
    bus.req_strb  = 4'h3;
    release_rsp("t5_hold", 5, 32'h00C0FFEE, 1'b0);
    run_xfer("t5_b", 8'h54, 1'b1, 32'h11223344, 4'h3, 0, 32'h0, 1'b0,
             1'b0, 32'h0, 1);
    release_rsp("t5b", 0, 32'h0, 1'b0);

    // Asynchronous reset in the middle of ACCESS.
    bus.req_valid = 1'b1;
    bus.req_addr  = 8'h5C;
    bus.req_write = 1'b1;
    bus.req_wdata = 32'hA5A5A5A5;
    bus.req_strb  = 4'hF;
    step();
    bus.req_valid = 1'b0;
    step();
    check_eq("t6_in_access", 64'({bus.psel, bus.penable}), 64'd3);
    #2;
    presetn = 1'b0;
    #1;
    check_eq("t6_async_drop", 64'({bus.psel, bus.penable, bus.rsp_valid, bus.req_ready}),
             64'd1);
    #3;
    presetn = 1'b1;
    step();
    check_eq("t6_after_reset", 64'({bus.rsp_valid, bus.req_ready, bus.psel}), 64'd2);
    run_xfer("t6_rd", 8'h60, 1'b0, 32'h0, 4'hF, 0, 32'h600DF00D, 1'b0,
             1'b0, 32'h600DF00D, 1);
    release_rsp("t6", 0, 32'h600DF00D, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
